alpha_fade_sequencer: RTL and testbench
=======================================

# alpha_fade_sequencer

Frame-synchronous generator of the 8-bit `alpha` blend factor consumed by the alpha blender. It accepts a fade command (direction, step, hold time) over a valid/ready handshake. It then ramps `alpha` by a saturating step once per frame, holds at the end value for a programmed number of frames, and reports completion. `alpha` changes only in response to `frame_start`, so the blender never sees a mid-frame change.

## Interface
- `ALPHA_W`, 8: width of `alpha` and `cmd_step`. Full scale is `2**ALPHA_W-1`.
- `HOLD_W`, 8: width of `cmd_hold` and of the internal hold counter.
- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse at the start of each frame.
- `cmd_valid` in 1: fade command present.
- `cmd_ready` out 1: block can accept a command. High only in IDLE.
- `cmd_dir` in 1: 1 = fade in (toward full scale), 0 = fade out (toward 0).
- `cmd_step` in ALPHA_W: alpha increment per frame. A value of 0 is treated as 1.
- `cmd_hold` in HOLD_W: number of frames to hold at the end value.
- `abort` in 1: cancels the active command.
- `alpha` out ALPHA_W: registered blend factor driven to the blender.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE: `cmd_ready`=1.
  - ARMED: command latched, waiting for a frame boundary.
  - RAMP: stepping `alpha` toward the end value.
  - HOLD: counting hold frames.
- Command handshake: a command is accepted when `cmd_valid && cmd_ready`. On acceptance, `dir`, `step` and `hold` are latched and the state goes IDLE→ARMED. Command inputs are ignored at all other times.
- ARMED→RAMP on `frame_start`. That same pulse performs the first step.
- The ramp starts from the current `alpha` value; there is no jump to 0 or full scale.
- Step arithmetic uses ALPHA_W+1 bits with saturation:
  - Fade in: `alpha = min(alpha+step, MAX)`.
  - Fade out: `alpha = max(alpha-step, 0)`.
  - Wrap-around is impossible.
- In RAMP, each `frame_start` applies one step. The step that reaches the end value (MAX or 0) also ends the ramp:
  - `hold==0`: go to IDLE and pulse `done` with the final `alpha` update.
  - Otherwise: go to HOLD with the counter loaded from `hold`.
- If `alpha` already equals the end value when the command is accepted, the first `frame_start` leaves `alpha` unchanged and takes the end-of-ramp path above.
- In HOLD, each `frame_start` decrements the counter. The decrement from 1→0 goes to IDLE and pulses `done`.
- `abort` in ARMED, RAMP or HOLD: go to IDLE on the next cycle, `alpha` keeps its current value, and no `done` is issued. `abort` in IDLE has no effect.
- Simultaneous events:
  - `abort` and `frame_start`: abort wins, no step is applied.
  - `frame_start` in the cycle of command acceptance: ignored (the block is still in IDLE).
- Reset values: state=IDLE, `alpha`=0, `busy`=0, `done`=0, `cmd_ready`=1 (combinational from IDLE). The hold counter and latched command fields are cleared.
- Reset mid-fade behaves identically to reset from IDLE.

## Timing
- `alpha` is registered and updates on the clock edge after the cycle in which `frame_start` is sampled (1-cycle latency).
- `done` rises in the same cycle as the terminating update and stays high for exactly one cycle.
- `busy` falls in that same cycle.
- `cmd_ready` is high in that same cycle, so a new command may be accepted back-to-back.
- Command acceptance to `busy`=1: 1 cycle.
- `frame_start` pulses closer than 2 cycles apart are not supported.

## Configuration
- `ALPHA_FADE_LOOP_EN` defined:
  - Adds input `loop_en` (1 bit), sampled at HOLD completion (or at ramp end when `hold==0`).
  - If `loop_en`=1, the latched direction inverts and the state goes to RAMP instead of IDLE. No `done` pulse is issued, and the next `frame_start` steps in the new direction (ping-pong).
  - Only `abort`, or `loop_en`=0 at a leg end, terminates the sequence.
- `ALPHA_FADE_LOOP_EN` undefined: the port is absent and every command is single-shot.

## Structure
- Package `alpha_fade_pkg` contains:
  - `alpha_fade_state_t` enum (IDLE, ARMED, RAMP, HOLD).
  - `ALPHA_MAX` constant derived from ALPHA_W.
  - A packed struct `alpha_fade_cmd_t` {dir, step, hold}.
- Sub-module `alpha_sat_step`: combinational saturating add/subtract (inputs alpha, step, dir; outputs next_alpha and at_end). The FSM instantiates it once.

## Test plan
- Reset, then 3 `frame_start` pulses with no command → `alpha` stays 0, `busy`=0, `done` never asserts.
- Fade in with step=64, hold=2, from `alpha`=0 → `alpha` sequence 64, 128, 192, 255 on successive frames. `done` pulses after the 2nd subsequent `frame_start`, one cycle wide.
- Fade out with step=0, hold=0, starting at `alpha`=3 → 2, 1, 0 (step=0 treated as 1). `done` asserts in the same cycle `alpha` becomes 0.
- Fade in with step=100; assert `abort` together with the 2nd `frame_start` → `alpha` stays at 100, the next cycle is IDLE, and there is no `done`.
- `done` cycle with `cmd_valid`=1 (fade out, step=255) → command accepted back-to-back, and the next `frame_start` gives `alpha`=0.
- With `ALPHA_FADE_LOOP_EN` and `loop_en`=1: step=128, hold=0 → `alpha` goes 128, 255, 127, 0, 128 ..., with no `done`. Deassert `loop_en` → `done` at the next end value.

Source files
------------

// File: rtl/alpha_fade_sequencer_pkg.sv
// Shared types and constants for the alpha fade sequencer.
// Widths are fixed here so that the package, the command interface and the
// RTL always agree on the size of alpha and of the hold counter.
package alpha_fade_pkg;

  localparam int ALPHA_W = 8;
  localparam int HOLD_W  = 8;

  // Full-scale alpha value, 2**ALPHA_W-1.
  localparam logic [ALPHA_W-1:0] ALPHA_MAX = {ALPHA_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RAMP  = 2'd2,
    HOLD  = 2'd3
  } alpha_fade_state_t;

  typedef struct packed {
    logic               dir;   // 1 = toward full scale, 0 = toward 0
    logic [ALPHA_W-1:0] step;  // per-frame increment, 0 behaves as 1
    logic [HOLD_W-1:0]  hold;  // frames to hold at the end value
  } alpha_fade_cmd_t;

endpackage

// File: rtl/alpha_fade_sequencer_if.sv
// Fade command valid/ready channel. The master presents a command, the
// sequencer (slave) returns cmd_ready while it is idle.
interface alpha_fade_sequencer_if;
  import alpha_fade_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_dir;
  logic [ALPHA_W-1:0] cmd_step;
  logic [HOLD_W-1:0]  cmd_hold;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_step,
    output cmd_hold,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_step,
    input  cmd_hold,
    output cmd_ready
  );

endinterface

// File: rtl/alpha_fade_sequencer_sat_step.sv
// alpha_sat_step: one saturating alpha step in either direction.
// Arithmetic is done one bit wider than alpha so the carry/borrow tells us
// when to clamp; a zero step is promoted to 1 so a ramp always progresses.
// at_end_o flags that the stepped value sits on the end value of the
// current direction (also true when alpha already started there).
module alpha_sat_step
  import alpha_fade_pkg::*;
(
  input  logic [ALPHA_W-1:0] alpha_i,
  input  logic [ALPHA_W-1:0] step_i,
  input  logic               dir_i,
  output logic [ALPHA_W-1:0] next_alpha_o,
  output logic               at_end_o
);

  logic [ALPHA_W-1:0] step_eff_s;
  logic [ALPHA_W:0]   sum_s;
  logic [ALPHA_W:0]   diff_s;

  // Saturating add or subtract of the effective step, plus end detection.
  always_comb begin
    step_eff_s   = step_i;
    next_alpha_o = alpha_i;
    at_end_o     = 1'b0;
    if (step_i == {ALPHA_W{1'b0}}) begin
      step_eff_s = {{(ALPHA_W-1){1'b0}}, 1'b1};
    end else begin
      step_eff_s = step_i;
    end
    sum_s  = {1'b0, alpha_i} + {1'b0, step_eff_s};
    diff_s = {1'b0, alpha_i} - {1'b0, step_eff_s};
    if (dir_i) begin
      if (sum_s[ALPHA_W]) begin
        next_alpha_o = ALPHA_MAX;
      end else begin
        next_alpha_o = sum_s[ALPHA_W-1:0];
      end
      at_end_o = (next_alpha_o == ALPHA_MAX);
    end else begin
      if (diff_s[ALPHA_W]) begin
        next_alpha_o = {ALPHA_W{1'b0}};
      end else begin
        next_alpha_o = diff_s[ALPHA_W-1:0];
      end
      at_end_o = (next_alpha_o == {ALPHA_W{1'b0}});
    end
  end

endmodule

// File: rtl/alpha_fade_sequencer.sv
// alpha_fade_sequencer: frame-synchronous alpha ramp generator.
// A command (direction, step, hold) is latched in IDLE; the first
// frame_start after that applies the first step, further frame_starts keep
// stepping until the end value, then the hold counter runs down and done
// pulses. alpha only ever changes on a frame_start (or never, on abort).
// Optional build macro: ALPHA_FADE_LOOP_EN adds the loop_en input, which
// turns each leg end into a direction reversal instead of completion.
module alpha_fade_sequencer
  import alpha_fade_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic                          abort,
  alpha_fade_sequencer_if.slave         cmd,
`ifdef ALPHA_FADE_LOOP_EN
  input  logic                          loop_en,
`endif
  output logic [ALPHA_W-1:0]            alpha,
  output logic                          busy,
  output logic                          done
);

  alpha_fade_state_t  state_q, state_d;
  alpha_fade_cmd_t    cmd_q, cmd_d;
  logic [ALPHA_W-1:0] alpha_q, alpha_d;
  logic [HOLD_W-1:0]  cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               leg_end_s;
  logic [ALPHA_W-1:0] step_alpha_s;
  logic               step_end_s;

  alpha_sat_step u_sat_step (
    .alpha_i      (alpha_q),
    .step_i       (cmd_q.step),
    .dir_i        (cmd_q.dir),
    .next_alpha_o (step_alpha_s),
    .at_end_o     (step_end_s)
  );

  // Next-state, alpha step, hold countdown and completion decode.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    alpha_d   = alpha_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    leg_end_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          cmd_d.dir  = cmd.cmd_dir;
          cmd_d.step = cmd.cmd_step;
          cmd_d.hold = cmd.cmd_hold;
          state_d    = ARMED;
        end else begin
          state_d = IDLE;
        end
      end
      ARMED, RAMP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (frame_start) begin
          alpha_d = step_alpha_s;
          if (step_end_s) begin
            if (cmd_q.hold == {HOLD_W{1'b0}}) begin
              leg_end_s = 1'b1;
            end else begin
              state_d = HOLD;
              cnt_d   = cmd_q.hold;
            end
          end else begin
            state_d = RAMP;
          end
        end else begin
          state_d = state_q;
        end
      end
      HOLD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (frame_start) begin
          cnt_d = cnt_q - HOLD_W'(1);
          if (cnt_q == HOLD_W'(1)) begin
            leg_end_s = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A finished leg either completes the command or reverses it.
    if (leg_end_s) begin
`ifdef ALPHA_FADE_LOOP_EN
      if (loop_en) begin
        cmd_d.dir = ~cmd_q.dir;
        state_d   = RAMP;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
`else
      state_d = IDLE;
      done_d  = 1'b1;
`endif
    end else begin
      done_d = 1'b0;
    end
  end

  // State, latched command, alpha, hold counter and done pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      alpha_q <= {ALPHA_W{1'b0}};
      cnt_q   <= {HOLD_W{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      alpha_q <= alpha_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign alpha         = alpha_q;
  assign done          = done_q;
  assign busy          = (state_q != IDLE);
  assign cmd.cmd_ready = (state_q == IDLE);

endmodule

// File: tb/tb_alpha_fade_sequencer.sv
// Testbench for alpha_fade_sequencer. Stimulus drives commands, frames and
// aborts; a reference model expands each accepted command into the list of
// alpha values it should produce, one per frame, and pushes the expected
// per-frame result into a scoreboard that an independent monitor drains.
module tb_alpha_fade_sequencer;
  import alpha_fade_pkg::*;

  typedef struct {
    int alpha;
    bit done;
    bit busy;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               frame_start;
  logic               abort;
  logic [ALPHA_W-1:0] alpha;
  logic               busy;
  logic               done;
  bit                 tb_loop = 1'b0;

  alpha_fade_sequencer_if cmd_if ();

`ifdef ALPHA_FADE_LOOP_EN
  logic loop_en;
  assign loop_en = tb_loop;
`endif

  alpha_fade_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .abort       (abort),
    .cmd         (cmd_if),
`ifdef ALPHA_FADE_LOOP_EN
    .loop_en     (loop_en),
`endif
    .alpha       (alpha),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_fail    = 0;
  int done_seen = 0;

  exp_t            exp_q[$];
  int              plan[$];   // alpha expected on each remaining frame
  alpha_fade_cmd_t m_cmd;
  int              m_alpha;
  bit              last_fs = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic alpha_fade_cmd_t mk(input bit d, input int s, input int h);
    alpha_fade_cmd_t c;
    c.dir  = d;
    c.step = ALPHA_W'(s);
    c.hold = HOLD_W'(h);
    return c;
  endfunction

  // Expand the current command into per-frame alpha values from m_alpha.
  function automatic void build_plan();
    int a   = m_alpha;
    int mx  = int'(ALPHA_MAX);
    int s   = (m_cmd.step == 0) ? 1 : int'(m_cmd.step);
    int tgt = m_cmd.dir ? mx : 0;
    plan.delete();
    do begin
      if (m_cmd.dir) a = (a + s > mx) ? mx : a + s;
      else           a = (a - s < 0) ? 0 : a - s;
      plan.push_back(a);
    end while (a != tgt);
    for (int i = 0; i < int'(m_cmd.hold); i++) plan.push_back(tgt);
  endfunction

  // Advance the model by one clock edge with the inputs that were applied.
  function automatic void model_clock(input bit fs, input bit ab, input bit cv,
                                      input alpha_fade_cmd_t c, input bit lp);
    exp_t e;
    bit   fin;
    if (plan.size() != 0) begin
      if (ab) begin
        plan.delete();
        if (fs) begin
          e.alpha = m_alpha; e.done = 1'b0; e.busy = 1'b0;
          exp_q.push_back(e);
        end
      end else if (fs) begin
        m_alpha = plan.pop_front();
        fin = (plan.size() == 0);
        if (fin && lp) begin
          m_cmd.dir = ~m_cmd.dir;
          build_plan();
          fin = 1'b0;
        end
        e.alpha = m_alpha; e.done = fin; e.busy = (plan.size() != 0);
        exp_q.push_back(e);
      end
    end else begin
      if (fs) begin
        e.alpha = m_alpha; e.done = 1'b0; e.busy = cv;
        exp_q.push_back(e);
      end
      if (cv) begin
        m_cmd = c;
        build_plan();
      end
    end
  endfunction

  // One cycle of stimulus, starting and ending at a falling edge.
  task automatic drive(input bit fs, input bit ab, input bit cv, input alpha_fade_cmd_t c);
    bit fs_eff;
    fs_eff = last_fs ? 1'b0 : fs;
    last_fs = fs_eff;
    frame_start      = fs_eff;
    abort            = ab;
    cmd_if.cmd_valid = cv;
    cmd_if.cmd_dir   = c.dir;
    cmd_if.cmd_step  = c.step;
    cmd_if.cmd_hold  = c.hold;
    #1;
    chk("cmd_ready", int'(cmd_if.cmd_ready), int'(plan.size() == 0));
    chk("busy", int'(busy), int'(plan.size() != 0));
    @(posedge clk);
    model_clock(fs_eff, ab, cv, c, tb_loop);
    @(negedge clk);
    frame_start      = 1'b0;
    abort            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, mk(1'b0, 0, 0));
  endtask

  task automatic frame_only();
    drive(1'b1, 1'b0, 1'b0, mk(1'b0, 0, 0));
  endtask

  task automatic frame();
    frame_only();
    idle();
  endtask

  task automatic send(input bit d, input int s, input int h);
    drive(1'b0, 1'b0, 1'b1, mk(d, s, h));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_start = 1'b0;
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    plan.delete();
    m_alpha = 0;
    m_cmd = mk(1'b0, 0, 0);
    last_fs = 1'b0;
  endtask

  // Monitor: after every sampled frame_start compare against the scoreboard.
  initial begin
    bit   fs_s;
    exp_t e;
    forever begin
      @(posedge clk);
      fs_s = (frame_start === 1'b1) && (rst === 1'b0);
      @(negedge clk);
      if (done === 1'b1) done_seen++;
      if (fs_s) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("frame_alpha", int'(alpha), e.alpha);
          chk("frame_done", int'(done), int'(e.done));
          chk("frame_busy", int'(busy), int'(e.busy));
        end
      end else if (rst === 1'b0) begin
        chk("done_outside_frame", int'(done), 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int r;
    alpha_fade_cmd_t rc;
    frame_start = 1'b0;
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_dir = 1'b0;
    cmd_if.cmd_step = '0;
    cmd_if.cmd_hold = '0;
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    chk("rst_alpha", int'(alpha), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cmd_ready", int'(cmd_if.cmd_ready), 1);

    // Frames with no command change nothing.
    d0 = done_seen;
    repeat (3) frame();
    chk("noop_alpha", int'(alpha), 0);
    chk("noop_done_count", done_seen - d0, 0);

    // Fade in 64/frame with a 2-frame hold: 64,128,192,255, then 2 holds.
    d0 = done_seen;
    send(1'b1, 64, 2);
    repeat (4) frame();
    chk("fadein_alpha_top", int'(alpha), 255);
    chk("fadein_busy_in_hold", int'(busy), 1);
    chk("fadein_done_before_hold", done_seen - d0, 0);
    repeat (2) frame();
    chk("fadein_done_count", done_seen - d0, 1);

    // Park alpha at 3, then fade out with step 0: 2,1,0 and done.
    do_reset();
    send(1'b1, 3, 0);
    frame();
    drive(1'b0, 1'b1, 1'b0, mk(1'b0, 0, 0));
    chk("park_alpha", int'(alpha), 3);
    d0 = done_seen;
    send(1'b0, 0, 0);
    repeat (2) frame();
    chk("step0_alpha", int'(alpha), 1);
    frame_only();
    chk("step0_final_alpha", int'(alpha), 0);
    chk("step0_done", int'(done), 1);
    idle();
    chk("step0_done_width", done_seen - d0, 1);

    // Fade in 100, abort together with the 2nd frame.
    d0 = done_seen;
    send(1'b1, 100, 0);
    frame();
    drive(1'b1, 1'b1, 1'b0, mk(1'b0, 0, 0));
    chk("abort_alpha", int'(alpha), 100);
    chk("abort_busy", int'(busy), 0);
    idle();
    chk("abort_no_done", done_seen - d0, 0);

    // Back-to-back: new command in the done cycle.
    send(1'b1, 255, 0);
    frame_only();
    chk("b2b_done", int'(done), 1);
    chk("b2b_alpha_top", int'(alpha), 255);
    send(1'b0, 255, 0);
    frame();
    chk("b2b_alpha_zero", int'(alpha), 0);

    // frame_start in the acceptance cycle is ignored.
    drive(1'b1, 1'b0, 1'b1, mk(1'b1, 40, 1));
    idle();
    chk("accept_frame_ignored", int'(alpha), 0);
    frame();
    chk("accept_then_step", int'(alpha), 40);

    // Reset in the middle of a fade.
    do_reset();
    chk("midreset_alpha", int'(alpha), 0);
    chk("midreset_busy", int'(busy), 0);

`ifdef ALPHA_FADE_LOOP_EN
    // Ping-pong: 128,255,127,0,128 with no done, then stop at next end.
    d0 = done_seen;
    tb_loop = 1'b1;
    send(1'b1, 128, 0);
    repeat (5) frame();
    chk("loop_alpha", int'(alpha), 128);
    chk("loop_no_done", done_seen - d0, 0);
    tb_loop = 1'b0;
    frame();
    chk("loop_end_alpha", int'(alpha), 255);
    chk("loop_end_done", done_seen - d0, 1);
    do_reset();
`endif

    // Randomized traffic.
    for (int it = 0; it < 600; it++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 2) == 0)
        rc = mk(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        rc = mk(1'($urandom_range(0, 1)), $urandom_range(16, 255), $urandom_range(0, 3));
      if (plan.size() == 0 && r < 30) begin
        drive($urandom_range(0, 9) == 0, 1'b0, 1'b1, rc);
      end else if (plan.size() != 0 && r < 4) begin
        drive(1'($urandom_range(0, 1)), 1'b1, 1'b0, rc);
      end else if (r < 75) begin
        drive(1'b1, 1'b0, $urandom_range(0, 4) == 0, rc);
      end else begin
        drive(1'b0, 1'b0, $urandom_range(0, 4) == 0, rc);
      end
    end

    repeat (3) idle();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
